// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2 from the register file, bypasses the
// concurrent write-back, tracks in-flight destinations and hands operands to execute.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [$clog2(NREG)-1:0] issue_rs1,
    input  logic [$clog2(NREG)-1:0] issue_rs2,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    input  logic                    issue_use_rs1,
    input  logic                    issue_use_rs2,
    input  logic                    issue_wr_rd,

    output logic [$clog2(NREG)-1:0] rf_rs1_addr,
    output logic [$clog2(NREG)-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]         rf_rs1_val,
    input  logic [XLEN-1:0]         rf_rs2_val,

    input  logic                    wb_valid,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [XLEN-1:0]         wb_result,

    input  logic                    flush,

    output logic                    ex_valid,
    input  logic                    ex_ready,
    output logic [XLEN-1:0]         ex_rs1_val,
    output logic [XLEN-1:0]         ex_rs2_val,
    output logic [$clog2(NREG)-1:0] ex_rd,
    output logic                    ex_wr_rd,

    output logic [NREG-1:0]         busy
);

    localparam int AW = $clog2(NREG);

    logic            wb_live;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic [XLEN-1:0] op_rs1;
    logic [XLEN-1:0] op_rs2;
    logic            haz_rs1;
    logic            haz_rs2;
    logic            haz_rd;
    logic            hazard;
    logic            accept;
    logic [NREG-1:0] busy_nxt;

    assign rf_rs1_addr = issue_rs1;
    assign rf_rs2_addr = issue_rs2;

    // A write-back to x0 is never a real commit, so it neither bypasses nor clears.
    assign wb_live = wb_valid && (wb_rd != '0);
    assign hit_rs1 = wb_live && (wb_rd == issue_rs1);
    assign hit_rs2 = wb_live && (wb_rd == issue_rs2);
    assign hit_rd  = wb_live && (wb_rd == issue_rd);

    always_comb begin
        op_rs1 = rf_rs1_val;
        if (issue_rs1 == '0) begin
            op_rs1 = '0;
        end else if (hit_rs1) begin
            op_rs1 = wb_result;
        end
    end

    always_comb begin
        op_rs2 = rf_rs2_val;
        if (issue_rs2 == '0) begin
            op_rs2 = '0;
        end else if (hit_rs2) begin
            op_rs2 = wb_result;
        end
    end

    assign haz_rs1 = issue_use_rs1 && busy[issue_rs1] && !hit_rs1;
    assign haz_rs2 = issue_use_rs2 && busy[issue_rs2] && !hit_rs2;
    assign haz_rd  = issue_wr_rd && (issue_rd != '0) && busy[issue_rd] && !hit_rd;
    assign hazard  = haz_rs1 || haz_rs2 || haz_rd;

    assign issue_ready = !flush && !hazard && (!ex_valid || ex_ready);
    assign accept      = issue_valid && issue_ready;

    // Clears are applied first so a newer writer of the same register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_live) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (flush && ex_valid && ex_wr_rd && (ex_rd != '0)) begin
            busy_nxt[ex_rd] = 1'b0;
        end
        if (accept && issue_wr_rd && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_rd      <= '0;
            ex_wr_rd   <= 1'b0;
        end else if (accept) begin
            ex_rs1_val <= op_rs1;
            ex_rs2_val <= op_rs2;
            ex_rd      <= issue_rd;
            ex_wr_rd   <= issue_wr_rd;
        end
    end

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; a small register-file model
// written by the same write-back bus feeds the read ports.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_use_rs1, issue_use_rs2, issue_wr_rd;
    logic [3:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_result;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_rs1_val, ex_rs2_val;
    logic [3:0]  ex_rd;
    logic        ex_wr_rd;
    logic [15:0] busy;

    logic [31:0] rf [16];
    logic        force_ones;
    int          n_cmp;
    int          n_err;

    operand_fetch #(.XLEN(32), .NREG(16)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_wr_rd(issue_wr_rd),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_wr_rd(ex_wr_rd),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: x7 starts at 0, others at 0x0A0A000i; written by write-back.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= (i == 0 || i == 7) ? 32'h0 : (32'h0A0A_0000 | i);
        end else if (wb_valid && wb_rd != 4'd0) begin
            rf[wb_rd] <= wb_result;
        end
    end

    assign rf_rs1_val = force_ones ? 32'hFFFF_FFFF : rf[rf_rs1_addr];
    assign rf_rs2_val = rf[rf_rs2_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic [3:0] rs1, input logic u1,
                               input logic [3:0] rs2, input logic u2,
                               input logic [3:0] rd, input logic wr);
        issue_valid   = v;
        issue_rs1     = rs1;
        issue_use_rs1 = u1;
        issue_rs2     = rs2;
        issue_use_rs2 = u2;
        issue_rd      = rd;
        issue_wr_rd   = wr;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        n_cmp++;
        if (busy !== 16'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0000", busy); end
        n_cmp++;
        if ({ex_rs1_val, ex_rs2_val, ex_rd, ex_wr_rd} !== 69'h0) begin
            n_err++;
            $display("FAIL reset_ex_data: got %h %h %h %b want zeros", ex_rs1_val, ex_rs2_val, ex_rd, ex_wr_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        ex_ready = 1'b1;
        drive_issue(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1);
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", issue_ready); end
        n_cmp++;
        if ({rf_rs1_addr, rf_rs2_addr} !== 8'h12) begin
            n_err++; $display("FAIL b2b_rf_addr: got %h want 12", {rf_rs1_addr, rf_rs2_addr});
        end
        tick();
        n_cmp++;
        if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd} !== {1'b1, 32'h0A0A_0001, 32'h0A0A_0002, 4'd3}) begin
            n_err++; $display("FAIL b2b_ex0: got %b %h %h %h want 1 0a0a0001 0a0a0002 3", ex_valid, ex_rs1_val, ex_rs2_val, ex_rd);
        end
        n_cmp++;
        if (busy !== 16'h0008) begin n_err++; $display("FAIL b2b_busy0: got %h want 0008", busy); end
        drive_issue(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 4'd4, 1'b1);
        tick();
        n_cmp++;
        if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd} !== {1'b1, 32'h0A0A_0005, 32'h0A0A_0006, 4'd4}) begin
            n_err++; $display("FAIL b2b_ex1: got %b %h %h %h want 1 0a0a0005 0a0a0006 4", ex_valid, ex_rs1_val, ex_rs2_val, ex_rd);
        end
        n_cmp++;
        if (busy !== 16'h0018) begin n_err++; $display("FAIL b2b_busy1: got %h want 0018", busy); end
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        wb_valid = 1'b1; wb_rd = 4'd3; wb_result = 32'h3333_3333;
        tick();
        n_cmp++;
        if ({ex_valid, busy} !== {1'b0, 16'h0010}) begin
            n_err++; $display("FAIL b2b_wb3: got ex_valid=%b busy=%h want 0 0010", ex_valid, busy);
        end
        wb_rd = 4'd4; wb_result = 32'h4444_4444;
        tick();
        wb_valid = 1'b0;
        n_cmp++;
        if (busy !== 16'h0000) begin n_err++; $display("FAIL b2b_wb4: got %h want 0000", busy); end
    endtask

    task automatic test_raw_bypass();
        drive_issue(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1);
        tick();
        n_cmp++;
        if (busy !== 16'h0080) begin n_err++; $display("FAIL raw_busy7: got %h want 0080", busy); end
        drive_issue(1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 4'd8, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall%0d: got %b want 0", c, issue_ready); end
            tick();
        end
        n_cmp++;
        if (ex_valid !== 1'b0) begin n_err++; $display("FAIL raw_bubble: got %b want 0", ex_valid); end
        wb_valid = 1'b1; wb_rd = 4'd7; wb_result = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", issue_ready); end
        tick();
        wb_valid = 1'b0;
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        n_cmp++;
        if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd} !== {1'b1, 32'hDEAD_BEEF, 32'h0A0A_0002, 4'd8}) begin
            n_err++; $display("FAIL raw_bypass: got %b %h %h %h want 1 deadbeef 0a0a0002 8", ex_valid, ex_rs1_val, ex_rs2_val, ex_rd);
        end
        n_cmp++;
        if (busy !== 16'h0100) begin n_err++; $display("FAIL raw_busy8: got %h want 0100", busy); end
        wb_valid = 1'b1; wb_rd = 4'd8; wb_result = 32'h8888_8888;
        tick();
        wb_valid = 1'b0;
        n_cmp++;
        if (busy !== 16'h0000) begin n_err++; $display("FAIL raw_clear: got %h want 0000", busy); end
    endtask

    task automatic test_x0();
        force_ones = 1'b1;
        drive_issue(1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 4'd0, 1'b1);
        wb_valid = 1'b1; wb_rd = 4'd0; wb_result = 32'h1234_5678;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", issue_ready); end
        tick();
        force_ones = 1'b0;
        n_cmp++;
        if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_wr_rd} !== {1'b1, 32'h0, 32'h0A0A_0002, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL x0_ex: got %b %h %h %h %b want 1 00000000 0a0a0002 0 1", ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_wr_rd);
        end
        n_cmp++;
        if (busy !== 16'h0000) begin n_err++; $display("FAIL x0_busy: got %h want 0000", busy); end
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL x0_no_waw: got %b want 1", issue_ready); end
        tick();
        wb_valid = 1'b0;
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        n_cmp++;
        if (rf[0] !== 32'h0) begin n_err++; $display("FAIL x0_rf_model: got %h want 00000000", rf[0]); end
        tick();
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0;
        drive_issue(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1);
        tick();
        n_cmp++;
        if ({ex_valid, busy} !== {1'b1, 16'h0020}) begin
            n_err++; $display("FAIL bp_load: got ex_valid=%b busy=%h want 1 0020", ex_valid, busy);
        end
        drive_issue(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (issue_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0", c, issue_ready); end
            tick();
            n_cmp++;
            if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd} !== {1'b1, 32'h3333_3333, 32'h4444_4444, 4'd5}) begin
                n_err++; $display("FAIL bp_hold%0d: got %b %h %h %h want 1 33333333 44444444 5", c, ex_valid, ex_rs1_val, ex_rs2_val, ex_rd);
            end
        end
        ex_ready = 1'b1;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", issue_ready); end
        tick();
        n_cmp++;
        if ({ex_valid, ex_rs1_val, ex_rd, busy} !== {1'b1, 32'h0A0A_0001, 4'd6, 16'h0060}) begin
            n_err++; $display("FAIL bp_next: got %b %h %h busy=%h want 1 0a0a0001 6 0060", ex_valid, ex_rs1_val, ex_rd, busy);
        end
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        wb_valid = 1'b1; wb_rd = 4'd5; wb_result = 32'h5555_5555;
        tick();
        wb_rd = 4'd6; wb_result = 32'h6666_6666;
        tick();
        wb_valid = 1'b0;
        n_cmp++;
        if (busy !== 16'h0000) begin n_err++; $display("FAIL bp_clear: got %h want 0000", busy); end
    endtask

    task automatic test_collision();
        drive_issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1);
        tick();
        n_cmp++;
        if (busy !== 16'h0200) begin n_err++; $display("FAIL col_busy9: got %h want 0200", busy); end
        drive_issue(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1);
        wb_valid = 1'b1; wb_rd = 4'd9; wb_result = 32'h9999_9999;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL col_ready: got %b want 1", issue_ready); end
        tick();
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        wb_valid = 1'b0;
        n_cmp++;
        if ({busy, ex_rs1_val} !== {16'h0200, 32'h9999_9999}) begin
            n_err++; $display("FAIL col_setwins: got busy=%h rs1=%h want 0200 99999999", busy, ex_rs1_val);
        end
        wb_valid = 1'b1; wb_rd = 4'd9; wb_result = 32'h9090_9090;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_flush();
        drive_issue(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd10, 1'b1);
        tick();
        drive_issue(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd12, 1'b1);
        tick();
        ex_ready = 1'b0;
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        n_cmp++;
        if ({ex_valid, ex_rd, busy} !== {1'b1, 4'd12, 16'h1400}) begin
            n_err++; $display("FAIL fl_setup: got %b %h busy=%h want 1 c 1400", ex_valid, ex_rd, busy);
        end
        flush = 1'b1;
        drive_issue(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1);
        wb_valid = 1'b1; wb_rd = 4'd10; wb_result = 32'hAAAA_AAAA;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", issue_ready); end
        tick();
        flush = 1'b0;
        wb_valid = 1'b0;
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        n_cmp++;
        if ({ex_valid, busy} !== {1'b0, 16'h0000}) begin
            n_err++; $display("FAIL fl_result: got ex_valid=%b busy=%h want 0 0000", ex_valid, busy);
        end
        ex_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0;
        drive_issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1);
        tick();
        drive_issue(1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1);
        #1;
        n_cmp++;
        if ({ex_valid, busy, issue_ready} !== {1'b1, 16'h0800, 1'b0}) begin
            n_err++; $display("FAIL ar_setup: got %b busy=%h ready=%b want 1 0800 0", ex_valid, busy, issue_ready);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ex_valid, busy, ex_rd, ex_wr_rd} !== {1'b0, 16'h0000, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL ar_async: got %b busy=%h rd=%h wr=%b want 0 0000 0 0", ex_valid, busy, ex_rd, ex_wr_rd);
        end
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        force_ones = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
        wb_valid = 1'b0;
        wb_rd = 4'd0;
        wb_result = 32'h0;
        drive_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        test_reset();
        test_back_to_back();
        test_raw_bypass();
        test_x0();
        test_backpressure();
        test_collision();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that drives the register file's read-address ports and delivers latched rs1/rs2 operands to execute over a valid/ready handshake. It keeps a 16-entry busy scoreboard of destination registers in flight between issue and write-back. It stalls issue on RAW/WAW hazards and bypasses the current write-back result so operands are never stale. It sits between decode (issue side) and execute; the write-back bus it snoops is the same one that writes the register file.

## Interface
- XLEN, 32, operand/result width
- NREG, 16, architectural registers (4-bit addresses); x0 hardwired zero
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  stage accepts this cycle
- issue_rs1, issue_rs2, issue_rd  in  4 each  register addresses
- issue_use_rs1, issue_use_rs2, issue_wr_rd  in  1 each  operand/destination enables
- rf_rs1_addr, rf_rs2_addr  out  4 each  register-file read addresses (combinational = issue_rs1/issue_rs2)
- rf_rs1_val, rf_rs2_val  in  XLEN each  register-file combinational read data
- wb_valid  in  1  write-back commits this cycle
- wb_rd  in  4  write-back destination
- wb_result  in  XLEN  write-back data
- flush  in  1  discard held instruction
- ex_valid  out  1  operands valid to execute
- ex_ready  in  1  execute accepts
- ex_rs1_val, ex_rs2_val  out  XLEN each  latched operands
- ex_rd  out  4, ex_wr_rd  out  1  latched destination info
- busy  out  NREG  scoreboard, for debug/verification

## Operation
- Reset: ex_valid=0, busy=0, ex_rs1_val=ex_rs2_val=0, ex_rd=0, ex_wr_rd=0.
- wb_hit(r) = wb_valid && wb_rd==r && r!=0.
- Operand select per source r: r==0 -> 0; wb_hit(r) -> wb_result; else rf value.
- Hazard: (use_rs1 && busy[rs1] && !wb_hit(rs1)) || (use_rs2 && busy[rs2] && !wb_hit(rs2)) || (wr_rd && rd!=0 && busy[rd] && !wb_hit(rd)). Unused sources never stall.
- issue_ready = !flush && !hazard && (!ex_valid || ex_ready). Combinational; must not depend on issue_valid.
- Accept (issue_valid && issue_ready): load ex_* from selected operands, ex_valid<=1; if wr_rd && rd!=0, set busy[rd].
- No accept and ex_ready: ex_valid<=0. Data regs hold when not loading.
- Write-back: wb_valid && wb_rd!=0 clears busy[wb_rd].
- Same register set and cleared in one cycle: set wins (the newer writer owns it).
- Flush: ex_valid<=0; if ex_valid && ex_wr_rd && ex_rd!=0, clear busy[ex_rd] (flushed instruction will never write back). Instructions already in execute keep their busy bits. A simultaneous wb clear is also applied.
- wb to x0 ignored everywhere; busy[0] permanently 0.

## Timing
- Issue to ex_valid: 1 cycle. Full throughput: one instruction per cycle when no hazard and ex_ready=1.
- Bypass is same-cycle: a producer writing back in cycle N lets a dependent instruction issue in cycle N with wb_result. The register-file write in that same edge makes later reads consistent.
- Stall releases the cycle wb_hit occurs; no extra bubble.
- ex_* is stable while ex_valid && !ex_ready (standard valid/ready hold).
- rst mid-operation: all state cleared asynchronously; held instruction lost; busy all zero.

## Test plan
- Back-to-back independent: issue x3<-(x1,x2), x4<-(x5,x6) with ex_ready=1 -> ex_valid on cycles 1,2; busy=0x0018 after cycle 2; wb x3 then x4 -> busy=0.
- RAW stall + bypass: issue writer of x7 (accepted), then reader of x7 -> issue_ready=0 until wb_valid,wb_rd=7,wb_result=0xDEADBEEF. In that cycle issue_ready=1 and next cycle ex_rs1_val=0xDEADBEEF, although rf returns old 0x0.
- x0 handling: issue with rs1=0, rf_rs1_val=0xFFFFFFFF, wr_rd=1,rd=0 -> ex_rs1_val=0, busy unchanged, no stall; wb_rd=0 ignored.
- Backpressure: ex_ready=0 with ex_valid=1 -> issue_ready=0, ex_* unchanged for 5 cycles; ex_ready=1 -> next instruction loads the same cycle.
- Set/clear collision: busy[9]=1, wb x9 while issuing new writer of x9 -> issue accepted (WAW bypassed), busy[9]=1 afterward.
- Flush and reset: held instruction with rd=12, flush=1 -> ex_valid=0, busy[12]=0, issue_ready=0 that cycle. Assert rst mid-stall -> ex_valid=0, busy=0 immediately, without waiting for a clock edge.
